// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-write target.
// Optional read support is compiled in with I2C_SLAVE_READ_EN.
// The write-only states use codes 0..7. The read states take the two
// codes above them, so a write-only build keeps its compact encoding.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_IGNORE    = 4'd7
`ifdef I2C_SLAVE_READ_EN
    ,
    ST_RDATA     = 4'd8,
    ST_RD_ACK    = 4'd9
`endif
  } state_e;

  // R/W bit carried in the LSB of the address byte
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Bus level seen during the acknowledge bit
  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered edge, START and STOP
// detection. Every output is registered, so an edge on the pins appears
// here 3 clk cycles later.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Synchronizers reset to 1, the idle bus level, so that releasing reset
  // does not look like a bus edge.
  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_rise_q, scl_rise_d;
  logic       scl_fall_q, scl_fall_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       sda_s_q, sda_s_d;
  logic       scl_now, sda_now;

  assign scl_now = scl_sync_q[1];
  assign sda_now = sda_sync_q[1];

  // Shift the synchronizers and classify the edges between the previous
  // and the current synchronized samples.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_now;
    sda_prev_d = sda_now;
    scl_rise_d = scl_now & ~scl_prev_q;
    scl_fall_d = ~scl_now & scl_prev_q;
    start_d    = scl_now & scl_prev_q & ~sda_now & sda_prev_q;
    stop_d     = scl_now & scl_prev_q & sda_now & ~sda_prev_q;
    sda_s_d    = sda_now;
  end

  // Register the synchronizers and the detector outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_s_q    <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_s_q    <= sda_s_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_s     = sda_s_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C register-write target: address match, register pointer, data bytes
// with one wr_valid strobe per byte. The pointer auto-increments and wraps.
// Define I2C_SLAVE_READ_EN to add register reads (rd_addr/rd_data ports).
// SDA is open-drain: the only levels driven are 0 and z.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
`ifdef I2C_SLAVE_READ_EN
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
`endif
  output logic       busy,
  output logic [3:0] states
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (i2c_scl),
    .sda_in    (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
`ifdef I2C_SLAVE_READ_EN
  logic       rw_q, rw_d;
`endif

  // Next-state logic. STOP and START override any bit handling in the same
  // cycle. A byte interrupted by either is dropped because the bit counter
  // restarts.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef I2C_SLAVE_READ_EN
    rw_d       = rw_q;
`endif
    if (stop_det) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                if (shift_d[7:1] == DEV_ADDR && shift_d[0] == RW_WRITE) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
`ifdef I2C_SLAVE_READ_EN
                  rw_d    = RW_WRITE;
                end else if (shift_d[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = RW_READ;
`endif
                end else begin
                  // Not ours (or a read without read support): stay off the bus.
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = shift_d;
                state_d = ST_REG_ACK;
              end else begin
                wr_valid_d = 1'b1;
                wr_data_d  = shift_d;
                wr_addr_d  = ptr_q;
                ptr_d      = ptr_q + 8'd1;
                state_d    = ST_WDATA_ACK;
              end
            end
          end
        end
        // The first SCL fall after bit 8 pulls SDA to ACK_LVL. The next
        // fall releases it and moves on to the following byte.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = (state_q == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
`ifdef I2C_SLAVE_READ_EN
              if (state_q == ST_ADDR_ACK && rw_q == RW_READ) begin
                state_d  = ST_RDATA;
                shift_d  = rd_data;
                sda_oe_d = ~rd_data[7];
              end
`endif
            end
          end
        end
`ifdef I2C_SLAVE_READ_EN
        // Count the master's sampling rises. Each fall presents the next bit.
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_d[7];
            end
          end
        end
        // bit_cnt flags that an ACK was seen. The following fall starts the next byte.
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK_LVL) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            shift_d   = rd_data;
            sda_oe_d  = ~rd_data[7];
          end
        end
`endif
        ST_IGNORE: sda_oe_d = 1'b0;
        ST_IDLE:   sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. An asynchronous reset releases SDA at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
`ifdef I2C_SLAVE_READ_EN
      rw_q       <= RW_WRITE;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef I2C_SLAVE_READ_EN
      rw_q       <= rw_d;
`endif
    end
  end

  assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign states   = state_q;
`ifdef I2C_SLAVE_READ_EN
  assign rd_addr  = ptr_q;
`endif

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-banged I2C master, a write monitor and
// a byte-level reference model of the expected ACKs and register writes.
// The read scenario is built when I2C_SLAVE_READ_EN is defined.
`timescale 1ns/1ps
module tb_i2c_slave_target;
  import i2c_pkg::*;

  localparam int         Q      = 10;     // clk cycles per quarter SCL period
  localparam logic [6:0] TB_DEV = 7'h21;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  wire        sda_bus;
  logic       wr_valid;
  logic [7:0] wr_addr, wr_data;
  logic       busy;
  logic [3:0] states;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_SLAVE_READ_EN
  logic [7:0] rd_addr, rd_data;
  logic [7:0] mem [0:255];
  assign rd_data = mem[rd_addr];
`endif

  i2c_slave_target dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i2c_scl  (scl),
    .i2c_sda  (sda_bus),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef I2C_SLAVE_READ_EN
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
`endif
    .busy     (busy),
    .states   (states)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];      // {wr_addr, wr_data} expected
  logic [15:0] obs_q[$];      // {wr_addr, wr_data} seen on the strobe
  logic [7:0]  txn_q[$];      // bytes the master sends after START
  logic        got_ack_q[$];  // 1 = target acknowledged
  logic        exp_ack_q[$];
  int          long_pulses = 0;
  int          dut_low_cycles = 0;
  logic        wr_valid_prev = 1'b0;

  // Monitor: capture each strobe, flag strobes wider than one cycle, and
  // count cycles where the target holds SDA low.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      if (wr_valid_prev) long_pulses <= long_pulses + 1;
      else obs_q.push_back({wr_addr, wr_data});
    end
    wr_valid_prev <= (wr_valid === 1'b1);
    if (sda_bus === 1'b0 && !tb_sda_low) dut_low_cycles <= dut_low_cycles + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic bus_start();
    tb_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    tb_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0;        wait_clk(Q);
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    tb_sda_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    tb_sda_low = ~b; wait_clk(Q);
    scl = 1'b1;      wait_clk(2 * Q);
    scl = 1'b0;      wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    tb_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    @(negedge clk) b = sda_bus;
    wait_clk(Q);
    scl = 1'b0;        wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(!master_ack);
    tb_sda_low = 1'b0;
  endtask

  task automatic drive_bytes();
    logic a;
    got_ack_q.delete();
    foreach (txn_q[i]) begin
      write_byte(txn_q[i], a);
      got_ack_q.push_back(a);
    end
  endtask

  // Reference model: a transaction addressed to TB_DEV for writing is fully
  // acknowledged. Byte 1 sets the pointer. Each later byte is written at
  // the pointer, which then steps by one modulo 256. Anything else gets no
  // acknowledge at all.
  task automatic model_txn();
    logic [7:0] ptr;
    logic       match;
    exp_ack_q.delete();
    match = (txn_q[0] == {TB_DEV, 1'b0});
    ptr = 8'h00;
    foreach (txn_q[i]) begin
      exp_ack_q.push_back(match);
      if (match && i == 1) ptr = txn_q[i];
      else if (match && i >= 2) begin
        exp_q.push_back({ptr, txn_q[i]});
        ptr = ptr + 8'd1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(3);
    n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    n_cmp++; if (wr_addr !== 8'h00) begin n_err++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", states, ST_IDLE); end
    n_cmp++; if (sda_bus !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want released(1)", sda_bus); end
`ifdef I2C_SLAVE_READ_EN
    n_cmp++; if (rd_addr !== 8'h00) begin n_err++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr); end
`endif
  endtask

  task automatic test_basic_write();
    logic [15:0] gw, ew;
    obs_q.delete(); exp_q.delete();
    txn_q = '{8'h42, 8'h10, 8'hA5};
    model_txn();
    bus_start();
    drive_bytes();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_before_stop: got %b want 1", busy); end
    bus_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after_stop: got %b want 0", busy); end
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL basic_state: got %0d want %0d", states, ST_IDLE); end
    foreach (exp_ack_q[i]) begin
      n_cmp++;
      if (got_ack_q[i] !== exp_ack_q[i]) begin n_err++; $display("FAIL basic_ack[%0d]: got %b want %b", i, got_ack_q[i], exp_ack_q[i]); end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      gw = obs_q.pop_front(); ew = exp_q.pop_front();
      n_cmp++;
      if (gw !== ew) begin n_err++; $display("FAIL basic_write: got addr %h data %h want addr %h data %h", gw[15:8], gw[7:0], ew[15:8], ew[7:0]); end
    end
  endtask

  task automatic test_addr_mismatch();
    int low0;
    obs_q.delete(); exp_q.delete();
    txn_q = '{8'h44, 8'h10, 8'h55};
    model_txn();
    low0 = dut_low_cycles;
    bus_start();
    drive_bytes();
    n_cmp++; if (states !== ST_IGNORE) begin n_err++; $display("FAIL nack_state: got %0d want %0d", states, ST_IGNORE); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nack_busy: got %b want 0", busy); end
    bus_stop();
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL nack_state_after_stop: got %0d want %0d", states, ST_IDLE); end
    n_cmp++; if (dut_low_cycles != low0) begin n_err++; $display("FAIL nack_sda_driven: got %0d low cycles want 0", dut_low_cycles - low0); end
    foreach (exp_ack_q[i]) begin
      n_cmp++;
      if (got_ack_q[i] !== exp_ack_q[i]) begin n_err++; $display("FAIL nack_ack[%0d]: got %b want %b", i, got_ack_q[i], exp_ack_q[i]); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL nack_wr_count: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_burst_wrap();
    logic [15:0] gw, ew;
    obs_q.delete(); exp_q.delete();
    long_pulses = 0;
    txn_q = '{8'h42, 8'hFF, 8'h11, 8'h22, 8'h33};
    model_txn();
    bus_start();
    drive_bytes();
    bus_stop();
    foreach (exp_ack_q[i]) begin
      n_cmp++;
      if (got_ack_q[i] !== exp_ack_q[i]) begin n_err++; $display("FAIL burst_ack[%0d]: got %b want %b", i, got_ack_q[i], exp_ack_q[i]); end
    end
    n_cmp++; if (long_pulses != 0) begin n_err++; $display("FAIL burst_strobe_width: got %0d wide strobes want 0", long_pulses); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL burst_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      gw = obs_q.pop_front(); ew = exp_q.pop_front();
      n_cmp++;
      if (gw !== ew) begin n_err++; $display("FAIL burst_write: got addr %h data %h want addr %h data %h", gw[15:8], gw[7:0], ew[15:8], ew[7:0]); end
    end
  endtask

  task automatic test_abort_mid_byte();
    logic        a;
    logic [7:0]  part;
    logic [15:0] gw, ew;
    obs_q.delete(); exp_q.delete();
    part = 8'hC3;
    bus_start();
    write_byte(8'h42, a);
    write_byte(8'h20, a);
    for (int i = 7; i >= 4; i--) write_bit(part[i]);
    bus_stop();
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL abort_state: got %0d want %0d", states, ST_IDLE); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_wr_count: got %0d want 0", obs_q.size()); end
    obs_q.delete();
    txn_q = '{8'h42, 8'h30, 8'h77};
    model_txn();
    bus_start();
    drive_bytes();
    bus_stop();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_follow_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      gw = obs_q.pop_front(); ew = exp_q.pop_front();
      n_cmp++;
      if (gw !== ew) begin n_err++; $display("FAIL abort_follow_write: got addr %h data %h want addr %h data %h", gw[15:8], gw[7:0], ew[15:8], ew[7:0]); end
    end
  endtask

  task automatic test_random();
    logic [6:0]  addr;
    logic [15:0] gw, ew;
    int          nd;
    for (int t = 0; t < 6; t++) begin
      obs_q.delete(); exp_q.delete();
      addr = TB_DEV;
      if ($urandom_range(0, 3) == 0) begin
        addr = 7'($urandom_range(0, 127));
        if (addr == TB_DEV) addr = 7'h22;
      end
      nd = $urandom_range(0, 4);
      txn_q.delete();
      txn_q.push_back({addr, 1'b0});
      txn_q.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < nd; k++) txn_q.push_back(8'($urandom_range(0, 255)));
      model_txn();
      bus_start();
      drive_bytes();
      bus_stop();
      foreach (exp_ack_q[i]) begin
        n_cmp++;
        if (got_ack_q[i] !== exp_ack_q[i]) begin n_err++; $display("FAIL rand%0d_ack[%0d]: got %b want %b", t, i, got_ack_q[i], exp_ack_q[i]); end
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_wr_count: got %0d want %0d", t, obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        gw = obs_q.pop_front(); ew = exp_q.pop_front();
        n_cmp++;
        if (gw !== ew) begin n_err++; $display("FAIL rand%0d_write: got addr %h data %h want addr %h data %h", t, gw[15:8], gw[7:0], ew[15:8], ew[7:0]); end
      end
    end
  endtask

`ifdef I2C_SLAVE_READ_EN
  task automatic test_read();
    logic       a;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[5] = 8'h5A;
    mem[6] = 8'h5B;
    obs_q.delete();
    bus_start();
    write_byte(8'h42, a);
    write_byte(8'h05, a);
    bus_start();
    write_byte(8'h43, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL read_addr_ack: got %b want 1", a); end
    n_cmp++; if (rd_addr !== 8'h05) begin n_err++; $display("FAIL read_rd_addr0: got %h want 05", rd_addr); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL read_byte0: got %h want 5a", d); end
    n_cmp++; if (rd_addr !== 8'h06) begin n_err++; $display("FAIL read_rd_addr1: got %h want 06", rd_addr); end
    read_byte(1'b0, d);
    n_cmp++; if (d !== 8'h5B) begin n_err++; $display("FAIL read_byte1: got %h want 5b", d); end
    n_cmp++; if (states !== ST_IGNORE) begin n_err++; $display("FAIL read_nack_state: got %0d want %0d", states, ST_IGNORE); end
    bus_stop();
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL read_state_after_stop: got %0d want %0d", states, ST_IDLE); end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL read_wr_count: got %0d want 0", obs_q.size()); end
  endtask
`else
  task automatic test_read_nack();
    int low0;
    obs_q.delete(); exp_q.delete();
    txn_q = '{8'h43, 8'h00};
    model_txn();
    low0 = dut_low_cycles;
    bus_start();
    drive_bytes();
    n_cmp++; if (states !== ST_IGNORE) begin n_err++; $display("FAIL rnack_state: got %0d want %0d", states, ST_IGNORE); end
    bus_stop();
    foreach (exp_ack_q[i]) begin
      n_cmp++;
      if (got_ack_q[i] !== exp_ack_q[i]) begin n_err++; $display("FAIL rnack_ack[%0d]: got %b want %b", i, got_ack_q[i], exp_ack_q[i]); end
    end
    n_cmp++; if (dut_low_cycles != low0) begin n_err++; $display("FAIL rnack_sda_driven: got %0d low cycles want 0", dut_low_cycles - low0); end
  endtask
`endif

  task automatic test_reset_mid_ack();
    logic [7:0] b;
    b = 8'h42;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    tb_sda_low = 1'b0;
    wait_clk(Q / 2);
    n_cmp++; if (states !== ST_ADDR_ACK) begin n_err++; $display("FAIL midack_state: got %0d want %0d", states, ST_ADDR_ACK); end
    n_cmp++; if (sda_bus !== 1'b0) begin n_err++; $display("FAIL midack_sda_low: got %b want 0", sda_bus); end
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (sda_bus !== 1'b1) begin n_err++; $display("FAIL midack_sda_release: got %b want released(1)", sda_bus); end
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL midack_reset_state: got %0d want %0d", states, ST_IDLE); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midack_reset_busy: got %b want 0", busy); end
    n_cmp++; if (wr_addr !== 8'h00 || wr_data !== 8'h00 || wr_valid !== 1'b0) begin
      n_err++; $display("FAIL midack_reset_outputs: got addr %h data %h valid %b want 00 00 0", wr_addr, wr_data, wr_valid);
    end
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    bus_stop();
    n_cmp++; if (states !== ST_IDLE) begin n_err++; $display("FAIL midack_recover_state: got %0d want %0d", states, ST_IDLE); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_write();
    test_addr_mismatch();
    test_burst_wrap();
    test_abort_mid_byte();
    test_random();
`ifdef I2C_SLAVE_READ_EN
    test_read();
`else
    test_read_nack();
`endif
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

I2C target (responder) for register writes, the far end of the team's I2C master. It runs on the system clock, oversamples SCL/SDA, detects START/STOP, matches a 7-bit device address, ACKs address, register-pointer and data bytes, and emits one write strobe per received data byte. With read support compiled in, it also returns register data to the master.

## Interface
- DEV_ADDR, 7'h21: 7-bit device address to match.
- clk  in  1  system clock, ≥ 8× SCL frequency (50 MHz nominal).
- reset_n  in  1  asynchronous, active-low reset.
- i2c_scl  in  1  bus clock (target never stretches).
- i2c_sda  inout  1  open-drain: drives 1'b0 or 1'bz, never 1.
- wr_valid  out  1  one-cycle strobe, write byte available.
- wr_addr  out  8  register pointer for the current write.
- wr_data  out  8  received data byte.
- rd_addr  out  8  register pointer for reads; only with I2C_SLAVE_READ_EN.
- rd_data  in  8  read data, sampled combinationally from rd_addr; only with I2C_SLAVE_READ_EN.
- busy  out  1  high from START match until STOP or NACK-abort.
- states  out  4  current FSM state encoding, for debug.

## Operation
- Sync SCL/SDA with two flops each, then form scl_rise, scl_fall, start_det and stop_det.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bits are sampled MSB-first on scl_rise. SDA is changed only on scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
- IDLE --start_det--> ADDR. After 8 bits:
  - Address match, R/W=0: go to ADDR_ACK, then REG.
  - Address match, R/W=1: go to ADDR_ACK, then RDATA (read builds only).
  - Mismatch, or R/W=1 in a write-only build: go to IGNORE and do not drive SDA, which gives a NACK.
- REG: 8 bits load the pointer, then REG_ACK, then WDATA.
- WDATA: on the 8th scl_rise, latch wr_data, set wr_addr to the pointer, and pulse wr_valid for one cycle. Then WDATA_ACK, then WDATA. The pointer increments after each byte and wraps 8'hFF→8'h00.
- ACK states: pull SDA low from the scl_fall after bit 8 until the next scl_fall, then release.
- RDATA: load rd_data at entry, shift out on each scl_fall, then RD_ACK samples the master's bit.
  - ACK: pointer++, next byte.
  - NACK: IGNORE.
- Global transitions, from any state:
  - stop_det → IDLE, busy=0.
  - start_det (repeated START) → ADDR.
  - Both take priority over the bit logic in the same cycle.
- A STOP or START mid-byte discards the partial byte. No wr_valid is issued.
- IGNORE releases SDA and waits for START or STOP.

## Timing
- Reset values:
  - SDA released (z).
  - wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0.
  - busy=0, states=IDLE.
  - Pointer 0, shift register 0.
- The reset release of SDA is asynchronous and immediate, including mid-ACK.
- Bus-edge detection latency is 3 clk cycles (2 sync + 1 edge register). All responses are referenced to the detected edge.
- wr_valid asserts 1 clk after the detected 8th scl_rise of a data byte and stays high exactly 1 cycle.
- The ACK or read-data drive changes 1 clk after the detected scl_fall.
- wr_addr and wr_data hold their values until the next strobe.

## Configuration
- I2C_SLAVE_READ_EN defined: rd_addr and rd_data ports exist, and the RDATA/RD_ACK states are active.
- Undefined:
  - Those ports and states are absent.
  - A read-address phase is NACKed and the FSM goes to IGNORE.
  - States are encoded as if write-only.

## Structure
- Shared package i2c_pkg holds:
  - FSM state localparams (4-bit encoding).
  - The R/W bit constants.
  - The ACK/NACK levels.
- Sub-module i2c_bus_sync does the two-flop synchronizers and edge/START/STOP detection. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

## Test plan
- Write 0x42 (addr 0x21 W), 0x10, 0xA5, STOP → three ACKs; one wr_valid with wr_addr=0x10, wr_data=0xA5; busy drops after STOP.
- Write addressed to 0x44 (addr 0x22) → SDA never driven low, NACK; no wr_valid; state IGNORE until STOP.
- Burst 0x42, 0xFF, 0x11, 0x22, 0x33 → wr_valid ×3 with wr_addr=0xFF, 0x00, 0x01 and data 0x11, 0x22, 0x33.
- STOP after 4 bits of a data byte → IDLE, no wr_valid; a following full write works normally.
- I2C_SLAVE_READ_EN: 0x42, 0x05, repeated START 0x43, master reads 2 bytes with ACK then NACK, rd_data=0x5A then 0x5B → SDA shows 0x5A then 0x5B; rd_addr is 0x05 then 0x06.
- Assert reset_n low during ADDR_ACK → SDA z in the same cycle; all outputs at reset values.
